// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the block-RAM initiator (mem_access_ctrl) and the
// RAM wrapper: controller state encoding, latency-counter width and the
// default word / address widths of the RAM.
package mem_ctrl_pkg;

    // Default RAM geometry, shared with the RAM wrapper
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    // Wide enough for READ_LATENCY values up to 4 (and a little headroom)
    localparam int LAT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter
// Loadable down-counter that tracks the RAM's registered read latency.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset (count cleared to 0)
//   load   in   load the counter with READ_LATENCY
//   dec    in   decrement by one (saturates at 0)
//   zero   out  count is 0
module mem_lat_counter
    import mem_ctrl_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [LAT_CNT_W-1:0] count;

    // Load has priority over decrement; the count never wraps below zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LAT_CNT_W'(READ_LATENCY);
        end else if (dec && (count != '0)) begin
            count <= count - LAT_CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Initiator side of the block-RAM interface. Accepts single-word load/store
// requests over a valid/ready handshake, drives RAM port A and returns a
// one-cycle response pulse (read data for loads, acknowledge for stores).
//
// Optional feature: define MEM_BOUNDS_CHECK_EN to reject requests with
// req_addr >= MEM_WORDS (no RAM access, resp_err=1). Without it resp_err is
// always 0 and every address goes to the RAM.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  controller can accept (IDLE and not in reset)
//   req_we      in   1 = store, 0 = load
//   req_addr    in   word address
//   req_wdata   in   store data
//   resp_valid  out  one-cycle completion pulse
//   resp_rdata  out  load data (0 for stores), held between pulses
//   resp_err    out  out-of-range access, qualified by resp_valid
//   ram_addr    out  RAM address
//   ram_data    out  RAM write data
//   ram_we      out  RAM write enable
//   ram_q       in   RAM read data
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int MEM_WORDS    = 512,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    // One extra bit so MEM_WORDS == 2**ADDR_WIDTH is still representable
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    state_t state;
    logic   accept;
    logic   addr_over;
    logic   out_of_range;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    // Ready is decoded from the state register but forced low while reset is
    // held, so it rises in the very first cycle after reset is released.
    assign req_ready    = (state == IDLE) && !reset;
    assign accept       = req_valid && req_ready;
    assign addr_over    = ({1'b0, req_addr} >= MEM_LIMIT);
    assign out_of_range = BOUNDS_EN && addr_over;

    assign cnt_load = accept && !req_we && !out_of_range;
    assign cnt_dec  = (state == READ_WAIT);

    mem_lat_counter #(
        .READ_LATENCY(READ_LATENCY)
    ) u_lat_counter (
        .clk  (clk),
        .reset(reset),
        .load (cnt_load),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    // Controller FSM with registered outputs. resp_valid, resp_err and
    // ram_we default low each cycle and are raised only on the edge that
    // enters the state in which they must be high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            ram_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (out_of_range) begin
                            // Rejected without touching the RAM port
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            ram_addr <= req_addr;
                            ram_data <= req_wdata;
                            if (req_we) begin
                                state      <= WRITE;
                                ram_we     <= 1'b1;
                                resp_valid <= 1'b1;
                                resp_rdata <= '0;
                            end else begin
                                state <= READ_WAIT;
                            end
                        end
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                READ_WAIT: begin
                    // Zero means ram_q already reflects ram_addr
                    if (cnt_zero) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ram_q;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Two controller instances (READ_LATENCY 1 and 2), each attached to its own
// behavioural RAM with matching registered read latency. Directed steps and
// randomized transactions are checked against a reference built from the
// protocol rules: stores and rejected requests answer in the first cycle
// after acceptance, loads answer READ_LATENCY+2 cycles after acceptance with
// the last data stored at that address.
// Honours MEM_BOUNDS_CHECK_EN the same way the design does.
module tb_mem_access_ctrl;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int NU = 2;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset      [NU];
    logic          req_valid  [NU];
    logic          req_ready  [NU];
    logic          req_we     [NU];
    logic [AW-1:0] req_addr   [NU];
    logic [DW-1:0] req_wdata  [NU];
    logic          resp_valid [NU];
    logic [DW-1:0] resp_rdata [NU];
    logic          resp_err   [NU];
    logic [AW-1:0] ram_addr   [NU];
    logic [DW-1:0] ram_data   [NU];
    logic          ram_we     [NU];
    logic [DW-1:0] ram_q      [NU];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference memory contents, per unit
    logic [DW-1:0] ref_mem [NU][1024];

    logic [AW-1:0] pool [9] = '{10'd0, 10'd3, 10'd5, 10'd100, 10'd255,
                                10'd510, 10'd511, 10'h200, 10'h3FF};

    for (genvar g = 0; g < NU; g++) begin : g_unit
        localparam int LAT = g + 1;
        logic [DW-1:0] mem  [1024];
        logic [DW-1:0] pipe [LAT];

        always @(posedge clk) begin
            if (ram_we[g]) mem[ram_addr[g]] <= ram_data[g];
            pipe[0] <= mem[ram_addr[g]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_q[g] = pipe[LAT-1];

        mem_access_ctrl #(
            .DATA_WIDTH  (DW),
            .ADDR_WIDTH  (AW),
            .MEM_WORDS   (512),
            .READ_LATENCY(LAT)
        ) dut (
            .clk       (clk),
            .reset     (reset[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g]),
            .ram_addr  (ram_addr[g]),
            .ram_data  (ram_data[g]),
            .ram_we    (ram_we[g]),
            .ram_q     (ram_q[g])
        );
    end

    task automatic checkOutput(input int u, input string tag,
                               input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL u%0d %s: observed %0h, expected %0h", u, tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds reset through one edge, checks reset values,
    // releases it and returns at the next negedge.
    task automatic resetUnit(input int u);
        reset[u] = 1'b1;
        @(negedge clk);
        checkOutput(u, "rst resp_valid", 32'(resp_valid[u]), 32'd0);
        checkOutput(u, "rst resp_rdata", 32'(resp_rdata[u]), 32'd0);
        checkOutput(u, "rst resp_err",   32'(resp_err[u]),   32'd0);
        checkOutput(u, "rst ram_we",     32'(ram_we[u]),     32'd0);
        checkOutput(u, "rst ram_addr",   32'(ram_addr[u]),   32'd0);
        checkOutput(u, "rst ram_data",   32'(ram_data[u]),   32'd0);
        checkOutput(u, "rst req_ready",  32'(req_ready[u]),  32'd0);
        reset[u] = 1'b0;
        #1;
        checkOutput(u, "post-rst req_ready", 32'(req_ready[u]), 32'd1);
        @(negedge clk);
    endtask

    // Called at a negedge; issues one request and checks every cycle up to
    // and including the cycle in which ready returns. Returns at that
    // negedge with req_valid low, so calls can run back to back.
    task automatic applyStimulus(input int u, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input bit hold);
        int w;
        int exp_lat;
        bit oob;
        bit ram_write;
        logic [DW-1:0] exp_rdata;

        oob       = BOUNDS_EN && (int'(addr) >= 512);
        ram_write = we && !oob;
        exp_lat   = (oob || we) ? 1 : (u + 1) + 2;
        exp_rdata = (oob || we) ? '0 : ref_mem[u][addr];

        req_we[u]    = we;
        req_addr[u]  = addr;
        req_wdata[u] = data;
        req_valid[u] = 1'b1;

        w = 0;
        while (req_ready[u] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput(u, "accept timeout", 32'(w < 20), 32'd1);

        @(negedge clk);
        if (!hold) req_valid[u] = 1'b0;

        for (int c = 1; c <= exp_lat + 1; c++) begin
            checkOutput(u, $sformatf("resp_valid c%0d", c), 32'(resp_valid[u]), 32'(c == exp_lat));
            checkOutput(u, $sformatf("req_ready c%0d", c),  32'(req_ready[u]),  32'(c == exp_lat + 1));
            checkOutput(u, $sformatf("ram_we c%0d", c),     32'(ram_we[u]),     32'(ram_write && c == 1));
            if (c == exp_lat) begin
                checkOutput(u, "resp_rdata", 32'(resp_rdata[u]), 32'(exp_rdata));
                checkOutput(u, "resp_err",   32'(resp_err[u]),   32'(oob));
            end
            if (c == 1 && !oob) begin
                checkOutput(u, "ram_addr", 32'(ram_addr[u]), 32'(addr));
                if (we) checkOutput(u, "ram_data", 32'(ram_data[u]), 32'(data));
            end
            if (c == exp_lat + 1) req_valid[u] = 1'b0;
            else @(negedge clk);
        end

        if (ram_write) ref_mem[u][addr] = data;
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            reset[u]     = 1'b1;
            req_valid[u] = 1'b0;
            req_we[u]    = 1'b0;
            req_addr[u]  = '0;
            req_wdata[u] = '0;
        end
        @(negedge clk);
        resetUnit(0);
        resetUnit(1);

        $display("[TB] store / load / held load on latency-1 unit");
        applyStimulus(0, 1'b1, 10'd3, 16'h00A5, 1'b0);
        applyStimulus(0, 1'b0, 10'd3, 16'h0000, 1'b0);
        applyStimulus(0, 1'b0, 10'd3, 16'h0000, 1'b1);

        $display("[TB] reset during a load");
        req_we[0]    = 1'b0;
        req_addr[0]  = 10'd3;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        resetUnit(0);
        checkOutput(0, "aborted resp_valid", 32'(resp_valid[0]), 32'd0);

        $display("[TB] back-to-back loads on latency-2 unit");
        applyStimulus(1, 1'b1, 10'd0,   16'h1234, 1'b0);
        applyStimulus(1, 1'b1, 10'd511, 16'hBEEF, 1'b0);
        applyStimulus(1, 1'b0, 10'd0,   16'h0000, 1'b0);
        applyStimulus(1, 1'b0, 10'd511, 16'h0000, 1'b0);

        $display("[TB] store to address 0x200");
        applyStimulus(0, 1'b1, 10'h200, 16'h5A5A, 1'b0);
        applyStimulus(1, 1'b1, 10'h200, 16'hC3C3, 1'b0);

        $display("[TB] randomized transactions");
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < 9; i++) begin
                applyStimulus(u, 1'b1, pool[i], DW'($urandom), 1'b0);
            end
        end
        for (int n = 0; n < 40; n++) begin
            applyStimulus($urandom_range(0, NU - 1), 1'($urandom_range(0, 1)),
                          pool[$urandom_range(0, 8)], DW'($urandom),
                          1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
